// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster bundle produced by vga_timing_gen and consumed by the
//                pixel-drawing blocks.
//                  hcounter    [11:0] current pixel column
//                  vcounter    [10:0] current line
//                  visible            inside the active picture area
//                  pix_en             one-clk strobe on every pixel advance
//                  frame_start        one-clk strobe on the advance to (0,0)
//                  HSYNC / VSYNC      sync pin levels
//                master : the timing generator (drives everything)
//                slave  : draw blocks (sample everything)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [11:0] hcounter;
    logic [10:0] vcounter;
    logic        visible;
    logic        pix_en;
    logic        frame_start;
    logic        HSYNC;
    logic        VSYNC;

    modport master (
        output hcounter, vcounter, visible, pix_en, frame_start, HSYNC, VSYNC
    );

    modport slave (
        input  hcounter, vcounter, visible, pix_en, frame_start, HSYNC, VSYNC
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Divides the board clock down to
//                the pixel rate and produces registered pixel/line counters,
//                the visible-area flag, pixel/frame strobes and HSYNC/VSYNC.
//                Every output is loaded from the decode of the *next*
//                position on the same edge the counters advance, so all
//                outputs are always mutually consistent.
//  Ports       : clk    board clock, rising edge
//                rst_n  asynchronous active-low reset
//                vga    raster bundle (master side of vga_timing_gen_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    vga_timing_gen_if.master   vga
);

    localparam int          c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] c_H_LAST   = 12'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
    localparam logic [11:0] c_H_VIS    = 12'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [11:0] c_HS_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] c_HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]  c_DIV_LAST = 4'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_div_cnt;
    logic        w_tick;

    logic [11:0] r_hcounter;
    logic [10:0] r_vcounter;
    logic        r_visible;
    logic        r_pix_en;
    logic        r_frame_start;
    logic        r_hsync;
    logic        r_vsync;

    logic [11:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_visible_next;
    logic        w_hsync_next;
    logic        w_vsync_next;

    // ------------------------------------------------------------------
    // Pixel-rate divider: tick on the last board clock of each pixel.
    // With CLK_DIV=1 the last count is 0, so the tick is permanent.
    // ------------------------------------------------------------------
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 4'd0;
        end else if (w_tick) begin
            r_div_cnt <= 4'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next raster position. WAIT presents (0,0) as the
    // position to load so the first tick produces a full (0,0) decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_hcounter;
        w_v_next     = r_vcounter;
        case (r_state)
            S_WAIT: begin
                w_h_next = 12'd0;
                w_v_next = 11'd0;
                if (w_tick) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_hcounter == c_H_LAST) begin
                    w_h_next = 12'd0;
                    w_v_next = (r_vcounter == c_V_LAST) ? 11'd0 : r_vcounter + 11'd1;
                end else begin
                    w_h_next = r_hcounter + 12'd1;
                end
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

    // Decode of the position about to be loaded; registered together with
    // the counters so outputs never lag them.
    always_comb begin
        w_visible_next = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
        w_hsync_next   = ((w_h_next >= c_HS_START) && (w_h_next < c_HS_END))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vsync_next   = ((w_v_next >= c_VS_START) && (w_v_next < c_VS_END))
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // ------------------------------------------------------------------
    // Output registers: load on tick, hold otherwise; strobes self-clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcounter    <= 12'd0;
            r_vcounter    <= 11'd0;
            r_visible     <= 1'b0;
            r_pix_en      <= 1'b0;
            r_frame_start <= 1'b0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
        end else if (w_tick) begin
            r_hcounter    <= w_h_next;
            r_vcounter    <= w_v_next;
            r_visible     <= w_visible_next;
            r_pix_en      <= 1'b1;
            r_frame_start <= (w_h_next == 12'd0) && (w_v_next == 11'd0);
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
        end else begin
            r_pix_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vga.hcounter    = r_hcounter;
    assign vga.vcounter    = r_vcounter;
    assign vga.visible     = r_visible;
    assign vga.pix_en      = r_pix_en;
    assign vga.frame_start = r_frame_start;
    assign vga.HSYNC       = r_hsync;
    assign vga.VSYNC       = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Two instances with a
//                scaled-down raster (15 x 8) are run side by side:
//                  dut0 : CLK_DIV=2, SYNC_ACTIVE=0
//                  dut1 : CLK_DIV=1, SYNC_ACTIVE=1
//                A reference model derives every expected output from the
//                number of clocks since reset release; a monitor compares
//                the DUT outputs every clock. Random mid-frame resets
//                exercise asynchronous reset and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int DIV0 = 2;
    localparam int DIV1 = 1;
    localparam bit SA0  = 1'b0;
    localparam bit SA1  = 1'b1;

    // {h[11:0], v[10:0], visible, pix_en, frame_start, HSYNC, VSYNC}
    typedef logic [27:0] rec_t;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    vga_timing_gen_if vga0();
    vga_timing_gen_if vga1();

    vga_timing_gen #(
        .CLK_DIV(DIV0), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vga0)
    );

    vga_timing_gen #(
        .CLK_DIV(DIV1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE(SA1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vga1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t reset_rec(bit sa);
        return {12'd0, 11'd0, 1'b0, 1'b0, 1'b0, ~sa, ~sa};
    endfunction

    // Expected outputs right after the k-th pixel tick (k=0 is the first).
    function automatic rec_t tick_rec(int k, bit sa);
        int h, v;
        bit vis, fs, hs, vs;
        h   = k % HT;
        v   = (k / HT) % VT;
        vis = (h < HV) && (v < VV);
        fs  = (h == 0) && (v == 0);
        hs  = (h >= HV + HF && h < HV + HF + HS) ? sa : ~sa;
        vs  = (v >= VV + VF && v < VV + VF + VS) ? sa : ~sa;
        return {12'(h), 11'(v), vis, 1'b1, fs, hs, vs};
    endfunction

    function automatic rec_t act0();
        return {vga0.hcounter, vga0.vcounter, vga0.visible, vga0.pix_en,
                vga0.frame_start, vga0.HSYNC, vga0.VSYNC};
    endfunction

    function automatic rec_t act1();
        return {vga1.hcounter, vga1.vcounter, vga1.visible, vga1.pix_en,
                vga1.frame_start, vga1.HSYNC, vga1.VSYNC};
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20) begin
                $display("FAIL %s t=%0t actual h=%0d v=%0d vis=%b pe=%b fs=%b hs=%b vs=%b required h=%0d v=%0d vis=%b pe=%b fs=%b hs=%b vs=%b",
                         name, $time,
                         act[27:16], act[15:5], act[4], act[3], act[2], act[1], act[0],
                         exp[27:16], exp[15:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts clocks since reset release and queues the
    // expected outputs for every clock on which a pixel tick is due.
    // ------------------------------------------------------------------
    int   cyc;
    rec_t q0[$];
    rec_t q1[$];

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                q0.delete();
                q1.delete();
            end else begin
                cyc = cyc + 1;
                if (cyc % DIV0 == 0) q0.push_back(tick_rec(cyc / DIV0 - 1, SA0));
                if (cyc % DIV1 == 0) q1.push_back(tick_rec(cyc / DIV1 - 1, SA1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: on each falling edge pop the due expectation (or hold the
    // previous values with strobes cleared) and compare.
    // ------------------------------------------------------------------
    rec_t cur0, cur1;

    initial begin
        cur0 = reset_rec(SA0);
        cur1 = reset_rec(SA1);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur0 = reset_rec(SA0);
                cur1 = reset_rec(SA1);
            end else begin
                if (q0.size() > 0) begin
                    cur0 = q0.pop_front();
                end else begin
                    cur0[3] = 1'b0;
                    cur0[2] = 1'b0;
                end
                if (q1.size() > 0) begin
                    cur1 = q1.pop_front();
                end else begin
                    cur1[3] = 1'b0;
                    cur1[2] = 1'b0;
                end
            end
            check("dut0_raster", act0(), cur0);
            check("dut1_raster", act1(), cur1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: initial reset, a few full frames, then random mid-frame
    // reset pulses with an immediate (asynchronous) reset-value check.
    // ------------------------------------------------------------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        repeat (3 * HT * VT * DIV0 + 17) @(posedge clk);

        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(20, 300)) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("dut0_async_reset", act0(), reset_rec(SA0));
            check("dut1_async_reset", act1(), reset_rec(SA1));
            @(posedge clk);
            @(negedge clk);
            #1 rst_n = 1'b1;
            repeat (HT * VT * DIV0 + 30) @(posedge clk);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster scan that the pixel-drawing blocks consume: horizontal and vertical pixel counters, a visible-area flag, and the HSYNC/VSYNC pins.
- Takes the board clock and divides it down to the pixel rate internally.
- Draw blocks such as the ball renderer decode hcounter/vcounter/visible combinationally into VGA_R/G/B, so all outputs here are registered and mutually consistent.
- Default timing is 640x480@60 from a 50 MHz clock.

Parameters:
- CLK_DIV, 2, board clocks per pixel (legal range 1..16).
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, HSYNC pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, VSYNC pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_ACTIVE, 0, level of HSYNC/VSYNC while their pulse is active.

Ports:
- clk  input  1  board clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hcounter  output  12  current pixel column, 0..H_TOTAL-1.
- vcounter  output  11  current line, 0..V_TOTAL-1.
- visible  output  1  high when hcounter<H_VISIBLE and vcounter<V_VISIBLE.
- pix_en  output  1  one-clk strobe, high on the clock in which the outputs above advance.
- frame_start  output  1  one-clk strobe on the pix_en that lands on (0,0).
- HSYNC  output  1  horizontal sync pin.
- VSYNC  output  1  vertical sync pin.

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset value of every output:
  - hcounter=0, vcounter=0, visible=0, pix_en=0, frame_start=0.
  - HSYNC=VSYNC=~SYNC_ACTIVE.
  - Internal div_cnt=0, state=WAIT.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - The internal tick is asserted when div_cnt==CLK_DIV-1.
  - With CLK_DIV=1 the tick is asserted every clock.
  - The first tick occurs CLK_DIV clocks after the reset release edge.
- State machine:
  - WAIT: counters hold at (0,0) and visible=0. On the first tick, outputs are loaded with the decode of (0,0): visible=1, frame_start=1, pix_en=1. Then go to RUN.
  - RUN: on each tick, advance the counters and load the decoded outputs for the new position in the same edge. Outputs never lag the counters.
  - No other transitions; only reset returns the block to WAIT.
- Advance rule (RUN, on tick):
  - If hcounter==H_TOTAL-1: hcounter wraps to 0 and vcounter increments.
  - If, in addition, vcounter==V_TOTAL-1: vcounter wraps to 0.
  - Otherwise hcounter increments.
  - No counter ever reaches H_TOTAL or V_TOTAL.
- Sync decode:
  - HSYNC=SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= hcounter < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - VSYNC=SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= vcounter < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - VSYNC is decoded from the line only and changes together with the wrap to hcounter=0.
- Strobes:
  - pix_en is high for exactly one clk per tick and low otherwise. It is constant 1 in RUN when CLK_DIV=1.
  - frame_start is high only on the tick that produces (0,0).
- Between ticks all outputs hold their values.
- Reset mid-frame: asserting rst_n=0 forces the reset values immediately (asynchronously). After release the sequence restarts from WAIT, with no partial-line or partial-frame carry-over.
- Widths: hcounter 12 bits and vcounter 11 bits are fixed port widths. Parameter combinations with H_TOTAL>4096 or V_TOTAL>2048 are illegal and are not checked.

Test Plan:
- Reset held 5 clks, then released -> during reset all outputs are at their reset values. With CLK_DIV=2, pix_en first rises on the 2nd clk after release, with hcounter=0, vcounter=0, visible=1, frame_start=1.
- Run one line -> hcounter visits 0..799 with exactly 2 clks per value. visible falls at h=640. HSYNC is low for h=656..751 (96 ticks) and high elsewhere.
- Line wrap at (799,10) -> next tick gives (0,11), frame_start=0, VSYNC unchanged.
- Frame wrap at (799,524) -> next tick gives (0,0) with frame_start=1. VSYNC is low only on lines 490 and 491. One full frame is 800*525*2=840000 clks between frame_start strobes.
- Reset pulsed at (300,200) for 1 clk -> outputs go to reset values asynchronously, before the next clk edge. Recovery repeats the first-scenario sequence from (0,0).
- CLK_DIV=1, SYNC_ACTIVE=1 build -> pix_en is high every clk in RUN. HSYNC is high only for h=656..751. The frame period is 420000 clks.
